// File: rtl/unified_buffer_arbiter.sv
// ============================================================================
// unified_buffer_arbiter
//   Single-port unified buffer SRAM arbiter: reader priority, round-robin
//   writers with starvation preemption, host burst lock, registered command.
//   Rev 1.0
// ============================================================================
`default_nettype none

module unified_buffer_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 256,
    parameter int STARVE_MAX = 15,
    parameter int BURST_MAX  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              host_req_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    input  logic              host_burst_i,
    output logic              host_gnt_o,
    input  logic              acc_req_i,
    input  logic [ADDR_W-1:0] acc_addr_i,
    input  logic [DATA_W-1:0] acc_wdata_i,
    output logic              acc_gnt_o,
    output logic              ub_en_o,
    output logic              ub_we_o,
    output logic [ADDR_W-1:0] ub_addr_o,
    output logic [DATA_W-1:0] ub_wdata_o,
    input  logic [DATA_W-1:0] ub_rdata_i
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              rr_q, rr_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [BW-1:0]     burst_q, burst_d;

    logic              en_q, we_q, rd_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              wr_pend, starved, host_pick, acc_pick;
    logic              rd_sel, host_sel, acc_sel, wr_sel;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    assign wr_pend   = host_req_i | acc_req_i;
    assign starved   = wr_pend && (starve_q == STARVE_TOP);
    // A lone writer wins outright; rr_q only breaks ties
    assign host_pick = host_req_i && (!acc_req_i || !rr_q);
    assign acc_pick  = acc_req_i && !host_pick;

    always_comb begin
        rd_sel   = 1'b0;
        host_sel = 1'b0;
        acc_sel  = 1'b0;
        if (state_q == ST_LOCK) begin
            host_sel = host_req_i;
        end else if (rd_req_i && !starved) begin
            rd_sel = 1'b1;
        end else begin
            host_sel = host_pick;
            acc_sel  = acc_pick;
        end
    end

    assign wr_sel     = host_sel | acc_sel;
    assign rd_gnt_o   = rst_i & rd_sel;
    assign host_gnt_o = rst_i & host_sel;
    assign acc_gnt_o  = rst_i & acc_sel;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        burst_d  = burst_q;
        starve_d = starve_q;

        if (wr_sel || !wr_pend) begin
            starve_d = '0;
        end else if (starve_q != STARVE_TOP) begin
            starve_d = starve_q + 1'b1;
        end

        if (host_sel) begin
            rr_d = 1'b1;
        end else if (acc_sel) begin
            rr_d = 1'b0;
        end

        if (state_q == ST_ARB) begin
            if (host_sel && host_burst_i) begin
                state_d = ST_LOCK;
                burst_d = BW'(1);
            end
        end else begin
            // Leaving the lock hands the next tie to the accumulator
            if (!host_req_i || burst_q == BURST_LAST) begin
                state_d = ST_ARB;
                rr_d    = 1'b1;
                burst_d = '0;
            end else begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    always_comb begin
        addr_mux  = rd_addr_i;
        wdata_mux = host_wdata_i;
        if (host_sel) begin
            addr_mux = host_addr_i;
        end else if (acc_sel) begin
            addr_mux  = acc_addr_i;
            wdata_mux = acc_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_ARB;
            rr_q       <= 1'b0;
            starve_q   <= '0;
            burst_q    <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            starve_q   <= starve_d;
            burst_q    <= burst_d;
            en_q       <= rd_sel | wr_sel;
            we_q       <= wr_sel;
            rd_valid_q <= en_q & ~we_q;
            if (rd_sel || wr_sel) begin
                addr_q <= addr_mux;
            end
            if (wr_sel) begin
                wdata_q <= wdata_mux;
            end
        end
    end

    assign ub_en_o    = en_q;
    assign ub_we_o    = we_q;
    assign ub_addr_o  = addr_q;
    assign ub_wdata_o = wdata_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = ub_rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_unified_buffer_arbiter.sv
// ============================================================================
// tb_unified_buffer_arbiter
//   Self-checking bench: SRAM model, command/read-data scoreboard, scenarios.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_unified_buffer_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 256;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_gnt_o, rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              host_req_i, host_burst_i, host_gnt_o;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic              acc_req_i, acc_gnt_o;
    logic [ADDR_W-1:0] acc_addr_i;
    logic [DATA_W-1:0] acc_wdata_i;
    logic              ub_en_o, ub_we_o;
    logic [ADDR_W-1:0] ub_addr_o;
    logic [DATA_W-1:0] ub_wdata_o;
    logic [DATA_W-1:0] ub_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    unified_buffer_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_gnt_o     (rd_gnt_o),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .host_req_i   (host_req_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_burst_i (host_burst_i),
        .host_gnt_o   (host_gnt_o),
        .acc_req_i    (acc_req_i),
        .acc_addr_i   (acc_addr_i),
        .acc_wdata_i  (acc_wdata_i),
        .acc_gnt_o    (acc_gnt_o),
        .ub_en_o      (ub_en_o),
        .ub_we_o      (ub_we_o),
        .ub_addr_o    (ub_addr_o),
        .ub_wdata_o   (ub_wdata_o),
        .ub_rdata_i   (ub_rdata_i)
    );

    // SRAM macro model, one-cycle read latency
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];

    always @(posedge clk_i) begin
        if (ub_en_o && ub_we_o)  mem[ub_addr_o] <= ub_wdata_o;
        if (ub_en_o && !ub_we_o) ub_rdata_i     <= mem[ub_addr_o];
    end

    // Scoreboard: expected command one cycle after grant, read data queued
    logic [DATA_W-1:0] rd_q[$];
    logic                       exp_en = 1'b0;
    logic [1+ADDR_W+DATA_W-1:0] exp_cmd = '0;
    logic [DATA_W-1:0]          last_wdata = '0;
    logic [DATA_W-1:0]          exp_rd;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            rd_q.delete();
            exp_en     = 1'b0;
            last_wdata = '0;
        end else begin
            checks++;
            if (ub_en_o !== exp_en) begin
                errors++;
                $display("FAIL sb_en: got %b want %b at %0t", ub_en_o, exp_en, $time);
            end
            if (exp_en) begin
                checks++;
                if ({ub_we_o, ub_addr_o, ub_wdata_o} !== exp_cmd) begin
                    errors++;
                    $display("FAIL sb_cmd: got we=%b addr=%h want we=%b addr=%h at %0t",
                             ub_we_o, ub_addr_o, exp_cmd[ADDR_W+DATA_W],
                             exp_cmd[ADDR_W+DATA_W-1 -: ADDR_W], $time);
                end
            end
            if (rd_valid_o) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_rd_unexpected: rd_valid_o=1 with no read pending at %0t", $time);
                end else begin
                    exp_rd = rd_q.pop_front();
                    if (rd_data_o !== exp_rd) begin
                        errors++;
                        $display("FAIL sb_rd_data: got %h want %h", rd_data_o[31:0], exp_rd[31:0]);
                    end
                end
            end
            exp_en = rd_gnt_o | host_gnt_o | acc_gnt_o;
            if (host_gnt_o) begin
                exp_cmd = {1'b1, host_addr_i, host_wdata_i};
                exp_mem[host_addr_i] = host_wdata_i;
                last_wdata = host_wdata_i;
            end else if (acc_gnt_o) begin
                exp_cmd = {1'b1, acc_addr_i, acc_wdata_i};
                exp_mem[acc_addr_i] = acc_wdata_i;
                last_wdata = acc_wdata_i;
            end else if (rd_gnt_o) begin
                exp_cmd = {1'b0, rd_addr_i, last_wdata};
                rd_q.push_back(exp_mem[rd_addr_i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        rd_req_i = 1'b1; rd_addr_i = 12'h001;
        host_req_i = 1'b1; host_burst_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
        acc_req_i = 1'b1; acc_addr_i = '0; acc_wdata_i = '0;
        repeat (2) tick();
        @(negedge clk_i);
        checks++;
        if ({rd_gnt_o, host_gnt_o, acc_gnt_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt: got %b want 000", {rd_gnt_o, host_gnt_o, acc_gnt_o});
        end
        tick();
        rd_req_i = 1'b0; host_req_i = 1'b0; acc_req_i = 1'b0;
        rst_i = 1'b1;
        repeat (2) tick();
        @(negedge clk_i);
        checks++;
        if ({ub_en_o, ub_we_o, rd_valid_o, rd_gnt_o, host_gnt_o, acc_gnt_o} !== 6'b0 ||
            ub_addr_o !== '0 || ub_wdata_o !== '0) begin
            errors++;
            $display("FAIL reset_idle: en=%b we=%b valid=%b addr=%h want all 0",
                     ub_en_o, ub_we_o, rd_valid_o, ub_addr_o);
        end
    endtask

    task automatic test_single_read();
        tick();
        rd_req_i = 1'b1; rd_addr_i = 12'h005;
        @(negedge clk_i);
        checks++;
        if (rd_gnt_o !== 1'b1) begin
            errors++; $display("FAIL read_gnt: got %b want 1", rd_gnt_o);
        end
        tick();
        rd_req_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ub_en_o !== 1'b1 || ub_we_o !== 1'b0 || ub_addr_o !== 12'h005) begin
            errors++;
            $display("FAIL read_cmd: en=%b we=%b addr=%h want 1 0 005", ub_en_o, ub_we_o, ub_addr_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (rd_valid_o !== 1'b1) begin
            errors++; $display("FAIL read_valid: got %b want 1", rd_valid_o);
        end
    endtask

    task automatic test_round_robin();
        int hn = 0;
        int an = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            host_req_i = 1'b1; host_addr_i = ADDR_W'(12'h200 + hn); host_wdata_i = {8{32'hB0000000 + 32'(hn)}};
            acc_req_i  = 1'b1; acc_addr_i  = ADDR_W'(12'h300 + an); acc_wdata_i  = {8{32'hC0000000 + 32'(an)}};
            @(negedge clk_i);
            checks++;
            if (host_gnt_o !== 1'((c % 2) == 0) || acc_gnt_o !== 1'((c % 2) == 1) || rd_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL rr_cycle%0d: host=%b acc=%b want host=%b", c, host_gnt_o, acc_gnt_o, 1'((c % 2) == 0));
            end
            if ((c % 2) == 0) hn++; else an++;
        end
        tick();
        host_req_i = 1'b0; acc_req_i = 1'b0;
    endtask

    task automatic test_write_then_read();
        host_req_i = 1'b1; host_addr_i = 12'h010; host_wdata_i = {32{8'hAA}};
        @(negedge clk_i);
        checks++;
        if (host_gnt_o !== 1'b1) begin
            errors++; $display("FAIL raw_wgnt: got %b want 1", host_gnt_o);
        end
        tick();
        host_req_i = 1'b0;
        rd_req_i = 1'b1; rd_addr_i = 12'h010;
        @(negedge clk_i);
        checks++;
        if (rd_gnt_o !== 1'b1) begin
            errors++; $display("FAIL raw_rgnt: got %b want 1", rd_gnt_o);
        end
        tick();
        rd_req_i = 1'b0;
        tick();
        @(negedge clk_i);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== {32{8'hAA}}) begin
            errors++;
            $display("FAIL raw_data: valid=%b data=%h want 1 aaaaaaaa", rd_valid_o, rd_data_o[31:0]);
        end
    endtask

    task automatic test_starvation();
        rd_req_i = 1'b1; rd_addr_i = 12'h010;
        for (int c = 0; c < 28; c++) begin
            tick();
            if (c == 10) begin
                acc_req_i = 1'b1; acc_addr_i = 12'h020; acc_wdata_i = {32{8'h5C}};
            end
            if (c == 26) acc_req_i = 1'b0;
            @(negedge clk_i);
            checks++;
            if (rd_gnt_o !== 1'(c != 25) || acc_gnt_o !== 1'(c == 25)) begin
                errors++;
                $display("FAIL starve_cycle%0d: rd=%b acc=%b want rd=%b acc=%b",
                         c, rd_gnt_o, acc_gnt_o, 1'(c != 25), 1'(c == 25));
            end
        end
        tick();
        rd_req_i = 1'b0;
    endtask

    task automatic test_burst_lock();
        host_req_i = 1'b1; host_burst_i = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (c > 0) tick();
            if (c == 1) begin
                rd_req_i = 1'b1; rd_addr_i = 12'h010;
            end
            host_addr_i  = ADDR_W'(12'h100 + ((c < 32) ? c : 32));
            host_wdata_i = {8{32'hD0000000 + 32'((c < 32) ? c : 32)}};
            @(negedge clk_i);
            checks++;
            if (host_gnt_o !== 1'(c < 32) || rd_gnt_o !== 1'(c >= 32) || acc_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL burst_cycle%0d: host=%b rd=%b want host=%b rd=%b",
                         c, host_gnt_o, rd_gnt_o, 1'(c < 32), 1'(c >= 32));
            end
        end
        tick();
        host_req_i = 1'b0; host_burst_i = 1'b0; rd_req_i = 1'b0;
    endtask

    task automatic test_reset_inflight();
        tick();
        rd_req_i = 1'b1; rd_addr_i = 12'h010;
        @(negedge clk_i);
        checks++;
        if (rd_gnt_o !== 1'b1) begin
            errors++; $display("FAIL inflight_gnt: got %b want 1", rd_gnt_o);
        end
        tick();
        rst_i = 1'b0;
        host_req_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if ({ub_en_o, ub_we_o, rd_valid_o, rd_gnt_o, host_gnt_o, acc_gnt_o} !== 6'b0 ||
                ub_addr_o !== '0 || ub_wdata_o !== '0) begin
                errors++;
                $display("FAIL inflight_rst%0d: en=%b valid=%b rdg=%b hg=%b want 0",
                         c, ub_en_o, rd_valid_o, rd_gnt_o, host_gnt_o);
            end
            tick();
        end
        host_req_i = 1'b0;
        rst_i = 1'b1;
        rd_addr_i = 12'h020;
        @(negedge clk_i);
        checks++;
        if (rd_gnt_o !== 1'b1) begin
            errors++; $display("FAIL post_rst_gnt: got %b want 1", rd_gnt_o);
        end
        tick();
        rd_req_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ub_en_o !== 1'b1 || ub_we_o !== 1'b0 || ub_addr_o !== 12'h020 || rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_cmd: en=%b we=%b addr=%h valid=%b want 1 0 020 0",
                     ub_en_o, ub_we_o, ub_addr_o, rd_valid_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== {32{8'h5C}}) begin
            errors++;
            $display("FAIL post_rst_data: valid=%b data=%h want 1 5c5c5c5c", rd_valid_o, rd_data_o[31:0]);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            exp_mem[i] = '0;
        end
        ub_rdata_i = '0;
        test_reset();
        test_single_read();
        repeat (2) tick();
        test_round_robin();
        repeat (2) tick();
        test_write_then_read();
        repeat (2) tick();
        test_starvation();
        repeat (3) tick();
        test_burst_lock();
        repeat (3) tick();
        test_reset_inflight();
        repeat (3) tick();
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d reads never returned", rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
